// File: rtl/sig_param_ctrl.sv
// Front-panel control for the signal generator: debounces three push-buttons and runs an
// IDLE / RUN / RELOAD menu machine that drives the generator parameter selects and confirm.
module sig_param_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned RELOAD_CYCLES   = 4,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_sel,
    input  logic       key_inc,
    input  logic       key_ok,
    output logic [1:0] cnt_sig,
    output logic [1:0] cnt_amp,
    output logic [1:0] cnt_fre,
    output logic [1:0] cnt_phase,
    output logic       confirm,
    output logic [1:0] field_sel,
    output logic       running
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RL_W = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RL_W-1:0] RL_LAST = RL_W'(RELOAD_CYCLES - 1);
    // Raw level of a released key, so the synchronisers come out of reset as "released".
    localparam logic [2:0] RAW_IDLE = {3{KEY_ACTIVE_LOW}};

    typedef enum logic [1:0] {StIdle, StRun, StReload} state_e;

    // Key vectors are indexed 0 = sel, 1 = inc, 2 = ok.
    logic [2:0]      w_key_raw;
    logic [2:0]      w_lvl;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_db;
    logic [2:0]      r_db_prev;
    logic [2:0]      r_press;
    logic [DB_W-1:0] r_db_cnt [3];

    logic            w_ok;
    logic            w_sel;
    logic            w_inc;

    state_e          r_state;
    state_e          w_state_d;
    logic [RL_W-1:0] r_gap;
    logic [RL_W-1:0] w_gap_d;
    logic            r_confirm;
    logic            r_running;
    logic            w_confirm_d;
    logic            w_running_d;

    logic [1:0]      r_field_sel;
    logic [1:0]      r_cnt_sig;
    logic [1:0]      r_cnt_amp;
    logic [1:0]      r_cnt_fre;
    logic [1:0]      r_cnt_phase;

    assign w_key_raw = {key_ok, key_inc, key_sel};
    // Normalise so that 1 always means pressed.
    assign w_lvl     = KEY_ACTIVE_LOW ? ~r_sync2 : r_sync2;

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= RAW_IDLE;
            r_sync2 <= RAW_IDLE;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce each key and register a one-cycle pulse on a released-to-pressed flip.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db      <= '0;
            r_db_prev <= '0;
            r_press   <= '0;
            for (int k = 0; k < 3; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_db_prev <= r_db;
            r_press   <= r_db & ~r_db_prev;
            for (int k = 0; k < 3; k++) begin
                if (w_lvl[k] == r_db[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_db[k]     <= w_lvl[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    // ok beats sel beats inc; losers in the same cycle are dropped.
    assign w_ok  = r_press[2];
    assign w_sel = r_press[0] & ~r_press[2];
    assign w_inc = r_press[1] & ~r_press[2] & ~r_press[0];

    // State register, gap counter and registered FSM outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_gap     <= '0;
            r_confirm <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_gap     <= w_gap_d;
            r_confirm <= w_confirm_d;
            r_running <= w_running_d;
        end
    end

    // Next-state logic; an inc in RUN or RELOAD (re)starts the confirm-low gap.
    always_comb begin
        w_state_d = r_state;
        w_gap_d   = r_gap;
        unique case (r_state)
            StIdle: begin
                if (w_ok) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (w_ok) begin
                    w_state_d = StIdle;
                end else if (w_inc) begin
                    w_state_d = StReload;
                    w_gap_d   = RL_LAST;
                end
            end
            StReload: begin
                if (w_ok) begin
                    w_state_d = StIdle;
                end else if (w_inc) begin
                    w_gap_d = RL_LAST;
                end else if (r_gap == '0) begin
                    w_state_d = StRun;
                end else begin
                    w_gap_d = r_gap - 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register.
    always_comb begin
        w_confirm_d = (w_state_d == StRun);
        w_running_d = (w_state_d != StIdle);
    end

    // Field pointer and parameter fields; editable in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_field_sel <= '0;
            r_cnt_sig   <= '0;
            r_cnt_amp   <= '0;
            r_cnt_fre   <= '0;
            r_cnt_phase <= '0;
        end else if (w_sel) begin
            r_field_sel <= r_field_sel + 1'b1;
        end else if (w_inc) begin
            unique case (r_field_sel)
                2'd0: r_cnt_sig   <= r_cnt_sig + 1'b1;
                2'd1: r_cnt_amp   <= r_cnt_amp + 1'b1;
                2'd2: r_cnt_fre   <= r_cnt_fre + 1'b1;
                2'd3: r_cnt_phase <= r_cnt_phase + 1'b1;
                default: ;
            endcase
        end
    end

    assign cnt_sig   = r_cnt_sig;
    assign cnt_amp   = r_cnt_amp;
    assign cnt_fre   = r_cnt_fre;
    assign cnt_phase = r_cnt_phase;
    assign field_sel = r_field_sel;
    assign confirm   = r_confirm;
    assign running   = r_running;

endmodule

// File: tb/tb_sig_param_ctrl.sv
// Scoreboard bench for sig_param_ctrl: stimulus pushes {cycle, expected outputs}; a monitor
// compares on the scheduled cycle and flags any output change nobody predicted.
module tb_sig_param_ctrl;

    typedef struct {
        int          at;
        logic [11:0] v;
        string       nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_sel, key_inc, key_ok;
    logic       f_sel, f_inc, f_ok;
    logic [1:0] cnt_sig, cnt_amp, cnt_fre, cnt_phase, field_sel;
    logic       confirm, running;
    logic [1:0] f_cnt_sig, f_cnt_amp, f_cnt_fre, f_cnt_phase, f_field_sel;
    logic       f_confirm, f_running;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   done = 1'b0;
    exp_t q_main[$];
    exp_t q_fast[$];
    logic [11:0] obs_m, obs_f, prev_m, prev_f;
    bit   hit;

    // Model of the expected output tuple for each instance.
    logic [1:0] m_s, m_a, m_f, m_p, m_fs;
    logic       m_cf, m_rn;
    logic [1:0] fm_s;
    logic       fm_cf, fm_rn;
    int         c;

    sig_param_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .RELOAD_CYCLES  (4),
        .KEY_ACTIVE_LOW (1'b1)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .key_sel  (key_sel),
        .key_inc  (key_inc),
        .key_ok   (key_ok),
        .cnt_sig  (cnt_sig),
        .cnt_amp  (cnt_amp),
        .cnt_fre  (cnt_fre),
        .cnt_phase(cnt_phase),
        .confirm  (confirm),
        .field_sel(field_sel),
        .running  (running)
    );

    // Short debounce, long gap: lets a second inc land inside a running gap.
    sig_param_ctrl #(
        .DEBOUNCE_CYCLES(2),
        .RELOAD_CYCLES  (8),
        .KEY_ACTIVE_LOW (1'b1)
    ) u_dut_fast (
        .clk      (clk),
        .rst      (rst),
        .key_sel  (f_sel),
        .key_inc  (f_inc),
        .key_ok   (f_ok),
        .cnt_sig  (f_cnt_sig),
        .cnt_amp  (f_cnt_amp),
        .cnt_fre  (f_cnt_fre),
        .cnt_phase(f_cnt_phase),
        .confirm  (f_confirm),
        .field_sel(f_field_sel),
        .running  (f_running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] pk(input logic [1:0] s, a, f, p, fs, input logic cf, rn);
        return {s, a, f, p, fs, cf, rn};
    endfunction

    task automatic exp_main(input int at, input string nm);
        exp_t e;
        e.at = at;
        e.v  = pk(m_s, m_a, m_f, m_p, m_fs, m_cf, m_rn);
        e.nm = nm;
        q_main.push_back(e);
    endtask

    task automatic exp_fast(input int at, input string nm);
        exp_t e;
        e.at = at;
        e.v  = pk(fm_s, 2'd0, 2'd0, 2'd0, 2'd0, fm_cf, fm_rn);
        e.nm = nm;
        q_fast.push_back(e);
    endtask

    // Called on a negedge: hold the chosen keys pressed for h samples, then let release settle.
    task automatic press(input bit p_ok, input bit p_sel, input bit p_inc, input int h);
        if (p_ok)  key_ok  = 1'b0;
        if (p_sel) key_sel = 1'b0;
        if (p_inc) key_inc = 1'b0;
        repeat (h) @(negedge clk);
        key_ok  = 1'b1;
        key_sel = 1'b1;
        key_inc = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    // Monitor for both instances; the only writer of the counters.
    always @(negedge clk) begin
        if (cyc >= 3) begin
            obs_m = pk(cnt_sig, cnt_amp, cnt_fre, cnt_phase, field_sel, confirm, running);
            obs_f = pk(f_cnt_sig, f_cnt_amp, f_cnt_fre, f_cnt_phase, f_field_sel,
                       f_confirm, f_running);
            while (q_main.size() > 0 && (q_main[0].at < cyc || done)) begin
                vectors++;
                miscompares++;
                $display("FAIL %s: not seen at cycle %0d, expected %03h", q_main[0].nm,
                         q_main[0].at, q_main[0].v);
                void'(q_main.pop_front());
            end
            hit = 1'b0;
            if (q_main.size() > 0 && q_main[0].at == cyc) begin
                vectors++;
                hit = 1'b1;
                if (obs_m !== q_main[0].v) begin
                    miscompares++;
                    $display("FAIL %s: got %03h expected %03h (cycle %0d)", q_main[0].nm,
                             obs_m, q_main[0].v, cyc);
                end
                void'(q_main.pop_front());
            end
            if (!hit && cyc > 3 && obs_m !== prev_m) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_change: got %03h expected %03h (cycle %0d)",
                         obs_m, prev_m, cyc);
            end
            prev_m = obs_m;

            while (q_fast.size() > 0 && (q_fast[0].at < cyc || done)) begin
                vectors++;
                miscompares++;
                $display("FAIL %s: not seen at cycle %0d, expected %03h", q_fast[0].nm,
                         q_fast[0].at, q_fast[0].v);
                void'(q_fast.pop_front());
            end
            hit = 1'b0;
            if (q_fast.size() > 0 && q_fast[0].at == cyc) begin
                vectors++;
                hit = 1'b1;
                if (obs_f !== q_fast[0].v) begin
                    miscompares++;
                    $display("FAIL %s: got %03h expected %03h (cycle %0d)", q_fast[0].nm,
                             obs_f, q_fast[0].v, cyc);
                end
                void'(q_fast.pop_front());
            end
            if (!hit && cyc > 3 && obs_f !== prev_f) begin
                vectors++;
                miscompares++;
                $display("FAIL f_unexpected_change: got %03h expected %03h (cycle %0d)",
                         obs_f, prev_f, cyc);
            end
            prev_f = obs_f;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected end", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        key_ok = 1'b1; key_sel = 1'b1; key_inc = 1'b1;
        f_ok = 1'b1; f_sel = 1'b1; f_inc = 1'b1;
        {m_s, m_a, m_f, m_p, m_fs, m_cf, m_rn} = '0;
        fm_s = 2'd0; fm_cf = 1'b0; fm_rn = 1'b0;

        // Reset for edges 1..3; ok pressed during reset only counts from the first free edge.
        @(negedge clk); @(negedge clk);
        exp_main(3, "reset_state");
        exp_fast(3, "f_reset_state");
        key_ok = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // First sample at edge 4, pulse after edge 14, RUN at edge 15.
        m_cf = 1'b1; m_rn = 1'b1;
        exp_main(15, "run_after_reset");
        repeat (10) @(negedge clk);
        key_ok = 1'b1;
        repeat (16) @(negedge clk);

        // 7-sample hold is a glitch: stays RUN.
        press(1'b1, 1'b0, 1'b0, 7);
        // Long hold stops once only.
        c = cyc; m_cf = 1'b0; m_rn = 1'b0;
        exp_main(c + 12, "stop_long_hold");
        press(1'b1, 1'b0, 1'b0, 100);
        press(1'b1, 1'b0, 1'b0, 7);

        // Field edit in IDLE: sel, sel, inc x5.
        c = cyc; m_fs = 2'd1; exp_main(c + 12, "sel_to_amp");
        press(1'b0, 1'b1, 1'b0, 10);
        c = cyc; m_fs = 2'd2; exp_main(c + 12, "sel_to_fre");
        press(1'b0, 1'b1, 1'b0, 10);
        for (int i = 1; i <= 5; i++) begin
            c = cyc; m_f = 2'(i % 4); exp_main(c + 12, "inc_fre_idle");
            press(1'b0, 1'b0, 1'b1, 10);
        end

        // Exactly 8 samples starts the generator.
        c = cyc; m_cf = 1'b1; m_rn = 1'b1; exp_main(c + 12, "start_hold8");
        press(1'b1, 1'b0, 1'b0, 8);
        c = cyc; m_fs = 2'd3; exp_main(c + 12, "sel_to_phase_run");
        press(1'b0, 1'b1, 1'b0, 10);
        c = cyc; m_fs = 2'd0; exp_main(c + 12, "sel_wrap_run");
        press(1'b0, 1'b1, 1'b0, 10);

        // In-run inc: confirm low for exactly 4 cycles.
        c = cyc; m_s = 2'd1; m_cf = 1'b0; exp_main(c + 12, "reload_start");
        m_cf = 1'b1; exp_main(c + 16, "reload_end");
        press(1'b0, 1'b0, 1'b1, 10);

        // ok and inc together: ok wins, field unchanged.
        c = cyc; m_cf = 1'b0; m_rn = 1'b0; exp_main(c + 12, "ok_beats_inc");
        press(1'b1, 1'b0, 1'b1, 10);
        c = cyc; m_cf = 1'b1; m_rn = 1'b1; exp_main(c + 12, "restart");
        press(1'b1, 1'b0, 1'b0, 10);

        // ok lands two cycles into a gap: go IDLE and never return to RUN.
        c = cyc; m_s = 2'd2; m_cf = 1'b0; exp_main(c + 12, "reload_again");
        m_rn = 1'b0; exp_main(c + 14, "ok_in_reload");
        key_inc = 1'b0;
        repeat (2) @(negedge clk);
        key_ok = 1'b0;
        repeat (8) @(negedge clk);
        key_inc = 1'b1;
        repeat (2) @(negedge clk);
        key_ok = 1'b1;
        repeat (20) @(negedge clk);

        // Wrap: move to phase, four incs wrap it, then sel wraps the pointer.
        for (int i = 1; i <= 3; i++) begin
            c = cyc; m_fs = 2'(i); exp_main(c + 12, "sel_walk");
            press(1'b0, 1'b1, 1'b0, 10);
        end
        for (int i = 1; i <= 4; i++) begin
            c = cyc; m_p = 2'(i % 4); exp_main(c + 12, "inc_phase_wrap");
            press(1'b0, 1'b0, 1'b1, 10);
        end
        c = cyc; m_fs = 2'd0; exp_main(c + 12, "sel_wrap_idle");
        press(1'b0, 1'b1, 1'b0, 10);

        // Fast instance: start, then two incs 6 cycles apart inside an 8-cycle gap.
        c = cyc; fm_cf = 1'b1; fm_rn = 1'b1; exp_fast(c + 6, "f_run");
        f_ok = 1'b0;
        repeat (3) @(negedge clk);
        f_ok = 1'b1;
        repeat (10) @(negedge clk);
        c = cyc;
        fm_s = 2'd1; fm_cf = 1'b0; exp_fast(c + 6, "f_inc1_gap");
        fm_s = 2'd2; exp_fast(c + 12, "f_inc2_in_gap");
        fm_cf = 1'b1; exp_fast(c + 20, "f_gap_end_6_plus_8");
        f_inc = 1'b0;
        repeat (3) @(negedge clk);
        f_inc = 1'b1;
        repeat (3) @(negedge clk);
        f_inc = 1'b0;
        repeat (3) @(negedge clk);
        f_inc = 1'b1;
        repeat (30) @(negedge clk);

        done = 1'b1;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
